fpga_debug_panel: RTL

FPGA_DEBUG_PANEL -- requirements
Module: fpga_debug_panel

---
 rtl/fpga_debug_panel.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/fpga_debug_panel.sv
// rtl/fpga_debug_panel.sv - debug panel: word/byte select to LEDs, 7-segment scan, CPU clock-enable control
// Optional macro FPGA_PANEL_STEP_EN builds the step-button debouncer and HALT/RUN/STEP FSM;
// without it the CPU enable is simply held on after reset.
module fpga_debug_panel #(
  parameter int NUM_WORDS  = 4,
  parameter int DEB_CYCLES = 16,
  parameter int SCAN_DIV   = 1024
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic [32*NUM_WORDS-1:0] iWords,
  input  logic [3:0]              iSel,
  input  logic [1:0]              iByteSel,
  input  logic                    iMode,
  input  logic                    iStep,
  output logic [7:0]              oLED,
  output logic [11:0]             oDigi,
  output logic                    oCpuClkEn,
  output logic [31:0]             oEnCount
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEB_CYCLES + 1);

  // Hex digit to active-low segments, decimal point (bit 7) always off.
  function automatic logic [7:0] hex_seg(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------
  // Channel / byte selection
  // ---------------------------------------------------------------
  logic [3:0]  sel_q;
  logic [1:0]  bsel_q;
  logic        valid_q;
  logic [31:0] word_sel;
  logic [7:0]  led_byte;

  // Register the selects; valid_q keeps the LEDs dark until the first post-reset sample.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      sel_q   <= 4'd0;
      bsel_q  <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      sel_q   <= iSel;
      bsel_q  <= iByteSel;
      valid_q <= 1'b1;
    end
  end

  // Pick the live word for the registered channel; out-of-range channels read as zero.
  always_comb begin
    word_sel = 32'h0000_0000;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (sel_q == 4'(k)) begin
        word_sel = iWords[k*32 +: 32];
      end
    end
  end

  // Pick the byte of the selected word shown on the LEDs.
  always_comb begin
    case (bsel_q)
      2'd0:    led_byte = word_sel[7:0];
      2'd1:    led_byte = word_sel[15:8];
      2'd2:    led_byte = word_sel[23:16];
      default: led_byte = word_sel[31:24];
    endcase
  end

  assign oLED = valid_q ? led_byte : 8'h00;

  // ---------------------------------------------------------------
  // 7-segment scan
  // ---------------------------------------------------------------
  logic [SW-1:0] scan_q, scan_d;
  logic [1:0]    dig_q, dig_d;
  logic [11:0]   digi_q, digi_d;
  logic [3:0]    nib;
  logic [3:0]    anode;

  // Scan prescaler and digit index; the digit advances when the prescaler wraps.
  always_comb begin
    scan_d = scan_q + SW'(1);
    dig_d  = dig_q;
    if (scan_q == SW'(SCAN_DIV - 1)) begin
      scan_d = '0;
      dig_d  = dig_q + 2'd1;
    end
  end

  // Anode and nibble for the current digit, combined into the next display word.
  always_comb begin
    case (dig_q)
      2'd0: begin
        anode = 4'b1110;
        nib   = word_sel[3:0];
      end
      2'd1: begin
        anode = 4'b1101;
        nib   = word_sel[7:4];
      end
      2'd2: begin
        anode = 4'b1011;
        nib   = word_sel[11:8];
      end
      default: begin
        anode = 4'b0111;
        nib   = word_sel[15:12];
      end
    endcase
    digi_d = {anode, hex_seg(nib)};
  end

  // Scan state and the display register; anode and segments update together.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      scan_q <= '0;
      dig_q  <= 2'd0;
      digi_q <= 12'hEFF;
    end else begin
      scan_q <= scan_d;
      dig_q  <= dig_d;
      digi_q <= digi_d;
    end
  end

  assign oDigi = digi_q;

  // ---------------------------------------------------------------
  // CPU clock enable
  // ---------------------------------------------------------------
  logic        en_q;
  logic [31:0] cnt_q;

`ifdef FPGA_PANEL_STEP_EN
  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          step_req_q, step_req_d;
  state_t        state_q, state_d;

  // Debounce: flip the level only after DEB_CYCLES straight disagreeing cycles.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DW'(DEB_CYCLES - 1)) begin
        deb_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
    end
    step_req_d = deb_d & ~deb_q;
  end

  // Synchroniser, debouncer state and the one-cycle step request.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_cnt_q  <= '0;
      step_req_q <= 1'b0;
    end else begin
      sync1_q    <= iStep;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_cnt_q  <= deb_cnt_d;
      step_req_q <= step_req_d;
    end
  end

  // Control FSM next state; a step request outside HALT is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALT: begin
        if (!iMode) begin
          state_d = ST_RUN;
        end else if (step_req_q) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (iMode) begin
          state_d = ST_HALT;
        end
      end
      ST_STEP: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  // State register; the enable register mirrors "state is RUN or STEP".
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= ST_HALT;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= (state_d != ST_HALT);
    end
  end
`else
  logic unused_step_inputs;
  assign unused_step_inputs = ^{iMode, iStep};

  // Free-running CPU: enabled from the first cycle after reset onwards.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      en_q <= 1'b0;
    end else begin
      en_q <= 1'b1;
    end
  end
`endif

  assign oCpuClkEn = en_q;

  // Count enabled cycles; wraps naturally at 32 bits.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_q + {31'd0, en_q};
    end
  end

  assign oEnCount = cnt_q;

endmodule
